// File: rtl/ksm_term_pkg.sv
// Shared constants, state encoding and code classification for the text-mode terminal writer.
package ksm_term_pkg;

  localparam int unsigned COLS      = 80;
  localparam int unsigned ROWS      = 25;
  localparam int unsigned FIRST_ROW = 1;
  localparam logic [15:0] BLANK     = 16'h2020;

  localparam logic [6:0] COL_LAST  = 7'(COLS - 1);
  localparam logic [4:0] ROW_FIRST = 5'(FIRST_ROW);
  localparam logic [4:0] ROW_LAST  = 5'(ROWS - 1);

  // Word indices: row 1 starts at word 40, the last text row at word 960.
  localparam logic [9:0] W_TEXT0     = 10'(FIRST_ROW * COLS / 2);
  localparam logic [9:0] W_COPY_LAST = 10'((ROWS - 1) * COLS / 2 - 1);
  localparam logic [9:0] W_END       = 10'(ROWS * COLS / 2 - 1);

  localparam logic [7:0] CH_BS = 8'h08;
  localparam logic [7:0] CH_LF = 8'h0A;
  localparam logic [7:0] CH_FF = 8'h0C;
  localparam logic [7:0] CH_CR = 8'h0D;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WRCH = 3'd1,
    ST_CPRD = 3'd2,
    ST_CPWR = 3'd3,
    ST_FILL = 3'd4
  } state_t;

  function automatic logic is_ctrl(input logic [7:0] c);
    return (c == CH_BS) || (c == CH_LF) || (c == CH_FF) || (c == CH_CR);
  endfunction

endpackage

// File: rtl/term_writer.sv
// Character stream to 80x25 video RAM writer with scroll and clear, as a wishbone master.
//
// state | meaning
// IDLE  | waiting for a character; in_ready high
// WRCH  | writing one glyph at the cursor
// CPRD  | scroll: reading the word one row below
// CPWR  | scroll: writing that word one row up
// FILL  | blanking words (bottom row after scroll, or whole text area on FF)
//
// Every bus state has two phases: r_cyc=1 holds the access until ack,
// r_cyc=0 is the mandatory idle cycle in which the next step is chosen.
module term_writer
  import ksm_term_pkg::*;
#(
  parameter logic [15:0] VRAM_BASE = 16'o0
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_n_i,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [15:0] wb_adr_o,
  output logic [15:0] wb_dat_o,
  input  logic [15:0] wb_dat_i,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  output logic [1:0]  wb_sel_o,
  input  logic        wb_ack_i,
  output logic [10:0] cursor,
  output logic        cursor_on
);

  state_t      r_state, w_state_nxt;
  logic        r_cyc, w_cyc_nxt;
  logic [6:0]  r_col;
  logic [4:0]  r_row;
  logic [9:0]  r_word;
  logic [15:0] r_rdata;
  logic [7:0]  r_char;
  logic        r_wrap_scroll;
  logic        r_ff;
  logic        w_ack;
  logic [9:0]  w_src;
  logic [10:0] w_cursor;

  assign w_ack    = r_cyc & wb_ack_i;
  assign w_src    = r_word + W_TEXT0;
  assign w_cursor = {r_row, 6'b0} + {2'b0, r_row, 4'b0} + {4'b0, r_col};
  assign cursor   = w_cursor;
  assign in_ready = (r_state == ST_IDLE);
  assign cursor_on = (r_state == ST_IDLE) || (r_state == ST_WRCH);

  // State and bus-phase register.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      r_state <= ST_IDLE;
      r_cyc   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cyc   <= w_cyc_nxt;
    end
  end

  // Next state: start access on entry, drop it after ack, advance in the idle phase.
  always_comb begin
    w_state_nxt = r_state;
    w_cyc_nxt   = r_cyc;
    case (r_state)
      ST_IDLE: begin
        if (in_valid) begin
          if (!is_ctrl(in_data)) begin
            w_state_nxt = ST_WRCH;
            w_cyc_nxt   = 1'b1;
          end else if ((in_data == CH_LF) && (r_row == ROW_LAST)) begin
            w_state_nxt = ST_CPRD;
            w_cyc_nxt   = 1'b1;
          end else if (in_data == CH_FF) begin
            w_state_nxt = ST_FILL;
            w_cyc_nxt   = 1'b1;
          end
        end
      end
      ST_WRCH: begin
        if (r_cyc) begin
          if (wb_ack_i) w_cyc_nxt = 1'b0;
        end else if (r_wrap_scroll) begin
          w_state_nxt = ST_CPRD;
          w_cyc_nxt   = 1'b1;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_CPRD: begin
        if (r_cyc) begin
          if (wb_ack_i) w_cyc_nxt = 1'b0;
        end else begin
          w_state_nxt = ST_CPWR;
          w_cyc_nxt   = 1'b1;
        end
      end
      ST_CPWR: begin
        if (r_cyc) begin
          if (wb_ack_i) w_cyc_nxt = 1'b0;
        end else begin
          w_state_nxt = (r_word == W_COPY_LAST) ? ST_FILL : ST_CPRD;
          w_cyc_nxt   = 1'b1;
        end
      end
      ST_FILL: begin
        if (r_cyc) begin
          if (wb_ack_i) w_cyc_nxt = 1'b0;
        end else if (r_word == W_END) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_cyc_nxt = 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cyc_nxt   = 1'b0;
      end
    endcase
  end

  // Cursor, word counter and data latches.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      r_col         <= 7'd0;
      r_row         <= ROW_FIRST;
      r_word        <= 10'd0;
      r_rdata       <= 16'd0;
      r_char        <= 8'd0;
      r_wrap_scroll <= 1'b0;
      r_ff          <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_char <= in_data;
            case (in_data)
              CH_BS: if (r_col != 7'd0) r_col <= r_col - 7'd1;
              CH_CR: r_col <= 7'd0;
              CH_LF: begin
                if (r_row != ROW_LAST) r_row <= r_row + 5'd1;
                else r_word <= W_TEXT0;
              end
              CH_FF: begin
                r_word <= W_TEXT0;
                r_ff   <= 1'b1;
              end
              default: ;
            endcase
          end
        end
        ST_WRCH: begin
          if (w_ack) begin
            if (r_col == COL_LAST) begin
              r_col <= 7'd0;
              if (r_row != ROW_LAST) r_row <= r_row + 5'd1;
              else r_wrap_scroll <= 1'b1;
            end else begin
              r_col <= r_col + 7'd1;
            end
          end else if (!r_cyc && r_wrap_scroll) begin
            r_wrap_scroll <= 1'b0;
            r_word        <= W_TEXT0;
          end
        end
        ST_CPRD: if (w_ack) r_rdata <= wb_dat_i;
        ST_CPWR: if (!r_cyc) r_word <= r_word + 10'd1;
        ST_FILL: begin
          if (!r_cyc) begin
            if (r_word == W_END) begin
              r_word <= 10'd0;
              if (r_ff) begin
                r_ff  <= 1'b0;
                r_col <= 7'd0;
                r_row <= ROW_FIRST;
              end
            end else begin
              r_word <= r_word + 10'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Bus outputs, forced to zero outside an active access.
  always_comb begin
    wb_cyc_o = 1'b0;
    wb_stb_o = 1'b0;
    wb_we_o  = 1'b0;
    wb_sel_o = 2'b00;
    wb_adr_o = 16'd0;
    wb_dat_o = 16'd0;
    if (r_cyc) begin
      wb_cyc_o = 1'b1;
      wb_stb_o = 1'b1;
      case (r_state)
        ST_WRCH: begin
          wb_we_o  = 1'b1;
          wb_adr_o = VRAM_BASE + {5'b0, w_cursor};
          wb_dat_o = {r_char, r_char};
          wb_sel_o = w_cursor[0] ? 2'b10 : 2'b01;
        end
        ST_CPRD: begin
          wb_adr_o = VRAM_BASE + {5'b0, w_src, 1'b0};
          wb_sel_o = 2'b11;
        end
        ST_CPWR: begin
          wb_we_o  = 1'b1;
          wb_adr_o = VRAM_BASE + {5'b0, r_word, 1'b0};
          wb_dat_o = r_rdata;
          wb_sel_o = 2'b11;
        end
        ST_FILL: begin
          wb_we_o  = 1'b1;
          wb_adr_o = VRAM_BASE + {5'b0, r_word, 1'b0};
          wb_dat_o = BLANK;
          wb_sel_o = 2'b11;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_term_writer.sv
// Scoreboard bench for term_writer: expected bus transactions are queued by the stimulus, a monitor compares them.
module tb_term_writer;

  localparam logic [15:0] VB = 16'h1000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  in_data = 8'd0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] wb_adr_o, wb_dat_o, wb_dat_i;
  logic        wb_cyc_o, wb_stb_o, wb_we_o, wb_ack_i;
  logic [1:0]  wb_sel_o;
  logic [10:0] cursor;
  logic        cursor_on;

  typedef struct {
    logic        we;
    logic [15:0] adr;
    logic [1:0]  sel;
    logic [15:0] dat;
  } txn_t;

  txn_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   n_txn = 0;
  int   ws = 0;
  int   wcnt = 0;
  int   m_row = 1;
  int   m_col = 0;

  always #5 clk = ~clk;

  term_writer #(.VRAM_BASE(VB)) dut (
    .wb_clk_i  (clk),
    .wb_rst_n_i(rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .wb_adr_o  (wb_adr_o),
    .wb_dat_o  (wb_dat_o),
    .wb_dat_i  (wb_dat_i),
    .wb_cyc_o  (wb_cyc_o),
    .wb_stb_o  (wb_stb_o),
    .wb_we_o   (wb_we_o),
    .wb_sel_o  (wb_sel_o),
    .wb_ack_i  (wb_ack_i),
    .cursor    (cursor),
    .cursor_on (cursor_on)
  );

  // Slave: ack after ws wait states; read data is a fixed function of the address.
  assign wb_ack_i = wb_cyc_o & wb_stb_o & (wcnt == ws);
  assign wb_dat_i = wb_adr_o ^ 16'hA5A5;

  initial forever begin
    @(posedge clk);
    if (wb_cyc_o && wb_stb_o && !wb_ack_i) wcnt <= wcnt + 1;
    else wcnt <= 0;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: transaction compare, hold-until-ack, idle cycle after ack.
  initial begin
    logic        p_stb, p_ack, p_we;
    logic [15:0] p_adr, p_dat;
    logic [1:0]  p_sel;
    txn_t        e;
    p_stb = 1'b0; p_ack = 1'b0; p_we = 1'b0; p_adr = '0; p_dat = '0; p_sel = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        p_stb = 1'b0;
        p_ack = 1'b0;
      end else begin
        if (p_stb && !p_ack) begin
          chk("held_stb", {63'd0, wb_stb_o}, 64'd1);
          if (wb_stb_o)
            chk("held_sig", {29'd0, wb_we_o, wb_sel_o, wb_adr_o, wb_dat_o},
                {29'd0, p_we, p_sel, p_adr, p_dat});
        end
        if (p_ack) chk("gap_after_ack", {63'd0, wb_cyc_o}, 64'd0);
        if (wb_cyc_o) chk("ready_in_bus", {63'd0, in_ready}, 64'd0);
        if (wb_cyc_o && wb_stb_o && wb_ack_i) begin
          n_txn++;
          if (sb.size() == 0) begin
            chk("unexpected_txn", {47'd0, wb_we_o, wb_adr_o}, 64'd0);
          end else begin
            e = sb.pop_front();
            chk("txn_we", {63'd0, wb_we_o}, {63'd0, e.we});
            chk("txn_adr", {48'd0, wb_adr_o}, {48'd0, e.adr});
            chk("txn_sel", {62'd0, wb_sel_o}, {62'd0, e.sel});
            if (e.we) chk("txn_dat", {48'd0, wb_dat_o}, {48'd0, e.dat});
          end
        end
        p_stb = wb_cyc_o & wb_stb_o;
        p_ack = wb_cyc_o & wb_stb_o & wb_ack_i;
        p_we  = wb_we_o;
        p_sel = wb_sel_o;
        p_adr = wb_adr_o;
        p_dat = wb_dat_o;
      end
    end
  end

  function automatic int m_cur();
    return m_row * 80 + m_col;
  endfunction

  task automatic push(input logic we, input int adr, input logic [1:0] sel, input logic [15:0] dat);
    txn_t t;
    t.we = we; t.adr = 16'(adr); t.sel = sel; t.dat = dat;
    sb.push_back(t);
  endtask

  task automatic push_fill(input int lo);
    for (int w = lo; w <= 999; w++) push(1'b1, VB + 2 * w, 2'b11, 16'h2020);
  endtask

  task automatic push_scroll();
    for (int w = 40; w <= 959; w++) begin
      push(1'b0, VB + 2 * (w + 40), 2'b11, 16'h0);
      push(1'b1, VB + 2 * w, 2'b11, 16'(VB + 2 * (w + 40)) ^ 16'hA5A5);
    end
    push_fill(960);
  endtask

  task automatic send(input logic [7:0] c);
    int k;
    k = 0;
    @(negedge clk);
    while (!in_ready && k < 5000) begin
      @(negedge clk);
      k++;
    end
    if (k >= 5000) chk("send_timeout", 64'd1, 64'd0);
    in_valid = 1'b1;
    in_data  = c;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = 8'd0;
  endtask

  task automatic model_lf();
    if (m_row < 24) m_row++;
    else push_scroll();
  endtask

  task automatic glyph(input logic [7:0] c);
    int cur;
    cur = m_cur();
    push(1'b1, VB + cur, (cur % 2 == 1) ? 2'b10 : 2'b01, {c, c});
    if (m_col == 79) begin
      m_col = 0;
      model_lf();
    end else begin
      m_col++;
    end
    send(c);
  endtask

  task automatic wait_quiet();
    int k;
    k = 0;
    @(negedge clk);
    while (!(in_ready && sb.size() == 0 && !wb_cyc_o) && k < 20000) begin
      @(negedge clk);
      k++;
    end
    if (k >= 20000) chk("quiet_timeout", {32'd0, 32'(sb.size())}, 64'd0);
  endtask

  initial begin
    int t0, k, viol;

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_bus", {27'd0, wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, wb_adr_o, wb_dat_o}, 64'd0);
    chk("rst_cursor", {53'd0, cursor}, 64'd80);
    chk("rst_flags", {62'd0, cursor_on, in_ready}, 64'd3);
    rst_n = 1'b1;

    // First glyph with exact latency
    push(1'b1, VB + 80, 2'b01, 16'h4141);
    m_col = 1;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 8'h41;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("lat_stb_n1", {63'd0, wb_stb_o}, 64'd1);
    @(negedge clk);
    chk("lat_gap_n2", {62'd0, wb_cyc_o, in_ready}, 64'd0);
    @(negedge clk);
    chk("lat_ready_n3", {63'd0, in_ready}, 64'd1);
    wait_quiet();
    chk("cursor_81", {53'd0, cursor}, 64'd81);

    // Fill row 1 up to col 79, then the autowrapping glyph
    for (int i = 0; i < 78; i++) glyph(8'(8'h61 + i % 26));
    wait_quiet();
    chk("cursor_159", {53'd0, cursor}, 64'd159);
    glyph(8'h42);
    wait_quiet();
    chk("cursor_160", {53'd0, cursor}, 64'd160);

    // Low control codes other than the four are glyphs
    glyph(8'h00);
    glyph(8'h1B);
    send(8'h0D);
    m_col = 0;

    // Move to 500, then clear screen
    for (int i = 0; i < 4; i++) begin
      send(8'h0A);
      model_lf();
    end
    for (int i = 0; i < 20; i++) glyph(8'h30);
    wait_quiet();
    chk("cursor_500", {53'd0, cursor}, 64'd500);
    push_fill(40);
    t0 = n_txn;
    send(8'h0C);
    viol = 0;
    k = 0;
    @(negedge clk);
    while (!in_ready && k < 5000) begin
      if (cursor_on) viol++;
      @(negedge clk);
      k++;
    end
    chk("ff_cursor_off", {32'd0, 32'(viol)}, 64'd0);
    wait_quiet();
    chk("ff_writes", {32'd0, 32'(n_txn - t0)}, 64'd960);
    chk("ff_cursor", {53'd0, cursor}, 64'd80);
    m_row = 1; m_col = 0;

    // BS at col 0, CR, BS mid-line
    t0 = n_txn;
    send(8'h08);
    wait_quiet();
    chk("bs_col0", {53'd0, cursor}, 64'd80);
    for (int i = 0; i < 15; i++) glyph(8'h2E);
    wait_quiet();
    chk("cursor_95", {53'd0, cursor}, 64'd95);
    t0 = n_txn;
    send(8'h0D);
    @(negedge clk);
    chk("cr_ready_next", {63'd0, in_ready}, 64'd1);
    wait_quiet();
    chk("cr_cursor", {53'd0, cursor}, 64'd80);
    chk("cr_no_bus", {32'd0, 32'(n_txn - t0)}, 64'd0);
    m_col = 0;
    for (int i = 0; i < 3; i++) glyph(8'h7A);
    send(8'h08);
    m_col--;
    wait_quiet();
    chk("bs_mid", {53'd0, cursor}, 64'd82);
    send(8'h0D);
    m_col = 0;

    // Walk to 1950 and scroll with LF
    for (int i = 0; i < 23; i++) begin
      send(8'h0A);
      model_lf();
    end
    for (int i = 0; i < 30; i++) glyph(8'h58);
    wait_quiet();
    chk("cursor_1950", {53'd0, cursor}, 64'd1950);
    t0 = n_txn;
    model_lf();
    send(8'h0A);
    wait_quiet();
    chk("scroll_txns", {32'd0, 32'(n_txn - t0)}, 64'd1880);
    chk("scroll_cursor", {53'd0, cursor}, 64'd1950);

    // Wait-state slave, reset in the middle of a scroll
    ws = 3;
    t0 = n_txn;
    model_lf();
    send(8'h0A);
    k = 0;
    while (n_txn < t0 + 6 && k < 1000) begin
      @(negedge clk);
      k++;
    end
    while (!(wb_cyc_o && !wb_ack_i) && k < 1000) begin
      @(negedge clk);
      k++;
    end
    chk("midscroll_reached", {63'd0, (k < 1000)}, 64'd1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("rst_async_bus", {62'd0, wb_cyc_o, wb_stb_o}, 64'd0);
    chk("rst_async_cursor", {53'd0, cursor}, 64'd80);
    chk("rst_async_ready", {63'd0, in_ready}, 64'd1);
    sb.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    m_row = 1; m_col = 0;
    repeat (3) @(negedge clk);
    chk("post_rst_idle", {62'd0, wb_cyc_o, in_ready}, 64'd1);
    glyph(8'h41);
    wait_quiet();
    chk("post_rst_cursor", {53'd0, cursor}, 64'd81);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
